// File: rtl/obstacle_pkg.sv
// Shared constants, FSM state type and LFSR parameters for the obstacle spawner.
package obstacle_pkg;

    localparam int unsigned OBS_SMALL = 0;
    localparam int unsigned OBS_BIG   = 1;
    localparam int unsigned OBS_BIRD  = 2;
    localparam int unsigned NUM_OBS   = 3;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned GAP_W = 10;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        PICK,
        FIRE
    } state_t;

    typedef logic [NUM_OBS-1:0] obs_vec_t;

endpackage

// File: rtl/obstacle_lfsr.sv
// 16-bit Galois LFSR used as the spawn randomness source; holds when adv is low.
module obstacle_lfsr
    import obstacle_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (adv) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Decides when and which obstacle to spawn: gap counting in column steps,
// randomised type choice with fallback to free obstacles, one-clk start pulses.
module obstacle_scheduler
    import obstacle_pkg::*;
#(
    parameter int unsigned       MIN_GAP   = 160,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic [1:0]       difficulty,
    input  logic [NUM_OBS-1:0] finish,
    output logic [NUM_OBS-1:0] start,
    output logic [CNT_W-1:0] spawn_cnt
);

    state_t            state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_reload;
    logic [LFSR_W-1:0] lfsr;
    obs_vec_t          inflight;
    obs_vec_t          finish_prev;
    obs_vec_t          finish_rise;
    obs_vec_t          free_obs;
    obs_vec_t          sel_onehot;
    logic [1:0]        cand;
    logic [1:0]        sel;
    logic [2:0]        idx;
    logic              found;
    logic              unused_lfsr_bits;

    obstacle_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (en),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    assign unused_lfsr_bits = ^{lfsr[15:10], lfsr[7]};
    assign finish_rise      = finish & ~finish_prev;
    assign free_obs         = finish & ~inflight;
    assign gap_reload       = GAP_W'(MIN_GAP) + GAP_W'(lfsr[6:0]) - GAP_W'({difficulty, 5'b00000});

    // Candidate from the LFSR, then rotate through the remaining types until a free one is found.
    always_comb begin
        cand  = lfsr[9:8];
        found = 1'b0;
        sel   = 2'd0;
        idx   = 3'd0;
        if (cand == 2'd3) begin
            cand = 2'd0;
        end
        if ((difficulty == 2'd0) && (cand == 2'(OBS_BIRD))) begin
            cand = 2'(OBS_BIG);
        end
        for (int unsigned k = 0; k < NUM_OBS; k++) begin
            idx = 3'(cand) + 3'(k);
            if (idx >= 3'(NUM_OBS)) begin
                idx = idx - 3'(NUM_OBS);
            end
            if (!found && free_obs[idx[1:0]] &&
                !((difficulty == 2'd0) && (idx == 3'(OBS_BIRD)))) begin
                found = 1'b1;
                sel   = idx[1:0];
            end
        end
        sel_onehot = obs_vec_t'(1) << sel;
    end

    // Spawn FSM; the spawn bookkeeping happens on the same edge that raises start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start       <= '0;
            spawn_cnt   <= '0;
            inflight    <= '0;
            gap_cnt     <= '0;
            finish_prev <= '1;
        end else begin
            start <= '0;
            if (!en) begin
                state <= IDLE;
            end else begin
                finish_prev <= finish;
                inflight    <= inflight & ~finish_rise;
                case (state)
                    IDLE: begin
                        gap_cnt <= GAP_W'(MIN_GAP);
                        state   <= GAP;
                    end
                    GAP: begin
                        if (step) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                            if (gap_cnt <= GAP_W'(1)) begin
                                state <= PICK;
                            end
                        end
                    end
                    PICK: begin
                        if (found) begin
                            start    <= sel_onehot;
                            inflight <= (inflight & ~finish_rise) | sel_onehot;
                            gap_cnt  <= gap_reload;
                            state    <= FIRE;
                            if (spawn_cnt != '1) begin
                                spawn_cnt <= spawn_cnt + CNT_W'(1);
                            end
                        end
                    end
                    FIRE: begin
                        state <= GAP;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 SHALL have parameter MIN_GAP, default 160, base spacing in column steps between spawns; SHALL be >= 97.
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero initial LFSR value.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  game running; low means idle or game over.
REQ-006 SHALL have port step  input  1  one-clk pulse per column scroll, matching the obstacle modules' move clock.
REQ-007 SHALL have port difficulty  input  2  0..3; higher values give shorter gaps and permit birds.
REQ-008 SHALL have port finish  input  3  per-obstacle finish flags; 1 means off-screen and free. Bit order: [0] small cactus, [1] big cactus, [2] birds.
REQ-009 SHALL have port start  output  3  one-clk spawn pulse per obstacle, driving the obstacle modules' start inputs.
REQ-010 SHALL have port spawn_cnt  output  16  total spawns issued, saturating at 16'hFFFF.

Function
REQ-011 SHALL implement a 16-bit Galois LFSR (taps 16'hB400) that advances every clk while en=1 and holds while en=0.
REQ-012 SHALL use FSM states IDLE, GAP, PICK and FIRE.
REQ-013 IDLE: when en=1, SHALL load gap_cnt=MIN_GAP and go to GAP, so the first spawn is deterministic.
REQ-014 GAP: SHALL decrement gap_cnt (10 bits) only on step=1; when step=1 and gap_cnt=1, SHALL go to PICK. step in other states SHALL be ignored.
REQ-015 PICK: SHALL take candidate type = lfsr[9:8], with value 3 mapped to 0.
REQ-016 PICK: when difficulty=0, a bird candidate SHALL be replaced by type 1.
REQ-017 PICK: SHALL search the candidate, then (c+1) mod 3, then (c+2) mod 3, skipping the bird when difficulty=0.
REQ-018 PICK: SHALL select the first type i with finish[i]=1 and inflight[i]=0.
REQ-019 PICK: if no type is free, SHALL stay in PICK and re-evaluate every cycle using the advancing LFSR.
REQ-020 FIRE: start[sel] SHALL be registered high for exactly one clk, the cycle after PICK resolved; all other start bits stay 0.
REQ-021 FIRE: SHALL set inflight[sel]=1, increment spawn_cnt, and load gap_cnt = MIN_GAP + lfsr[6:0] - 32*difficulty (range MIN_GAP-96 .. MIN_GAP+127); then go to GAP.
REQ-022 inflight[i] SHALL clear on a 0->1 edge of finish[i], using a registered previous value.
REQ-023 A finish edge coinciding with a FIRE on the same index SHALL leave inflight set (set wins).
REQ-024 en=0 in any state SHALL force IDLE on the next clk.
REQ-025 While en=0, start SHALL stay 3'b000 and spawn_cnt and inflight SHALL hold.
REQ-026 A pending FIRE aborted by en=0 SHALL emit no pulse.
REQ-027 At most one start bit SHALL be high in any cycle.

Reset
REQ-028 With rst=1 at a clk edge, SHALL set state=IDLE, start=0, spawn_cnt=0, inflight=0, gap_cnt=0, lfsr=LFSR_SEED and finish_prev=3'b111.
REQ-029 rst SHALL take priority over en and step, including mid-GAP and mid-FIRE; no start pulse SHALL follow a reset cycle.

Structure
REQ-030 Shared package obstacle_pkg SHALL hold OBS_SMALL=0, OBS_BIG=1, OBS_BIRD=2, NUM_OBS=3, the FSM state enum, LFSR_TAPS and the LFSR width.
REQ-031 The LFSR SHALL be the sub-module obstacle_lfsr (ports clk, rst, adv, seed, q); the FSM, gap counter and arbitration SHALL stay in obstacle_scheduler.
REQ-032 The target implementation size is 150-300 RTL lines.

Verification
REQ-033 Reset, en=1, finish=3'b111, one step every 4 clk: the first start pulse SHALL occur exactly 160 steps after en rises, plus 2 clk, and last one clk.
REQ-034 difficulty=0, 2000 steps, all obstacles finishing promptly: start[2] SHALL never assert, and every gap SHALL lie in 160..287 steps.
REQ-035 difficulty=3, with the LFSR forced to lfsr[6:0]=0 at FIRE: the next gap SHALL be 64 steps.
REQ-036 finish=3'b000 held when PICK is entered: the FSM SHALL stay in PICK with no start pulse.
REQ-037 Raising finish[1] in the REQ-036 scenario SHALL produce start=3'b010 within 2 clk.
REQ-038 en dropped in the cycle PICK resolves: no start pulse SHALL be issued, the FSM SHALL be in IDLE next clk, and spawn_cnt SHALL be unchanged.
REQ-039 rst asserted mid-GAP with spawn_cnt=5: spawn_cnt SHALL be 0, start SHALL be 0 and lfsr SHALL equal LFSR_SEED next clk.
